mux_scan_nx1: RTL and testbench
===============================

Name: mux_scan_nx1

Overview:
Parametrised, registered N:1 multiplexer of W-bit channels, the successor to the 8:1 lab mux. It has two modes.
- Manual mode: follows an external select.
- Scan mode: steps through the enabled channels by itself, holding each for DWELL cycles, with wrap detection.
It feeds display/sampling logic that needs a time-multiplexed channel stream with a known current index.

Parameters:
N_CH, 8, number of input channels (>=2, need not be a power of 2)
W, 1, bits per channel
DWELL, 4, cycles each channel is held in scan mode (>=1)
SW, $clog2(N_CH), select width (derived, not overridable)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in  in  N_CH*W  packed channels, channel k at in[k*W +: W]
sel  in  SW  manual-mode channel select
mode  in  1  0 = manual, 1 = scan
en_mask  in  N_CH  scan-mode channel enables, bit k enables channel k
out  out  W  registered selected channel data
cur_sel  out  SW  index driving out; always consistent with out
out_valid  out  1  out holds a legal channel's data
wrap  out  1  one-cycle pulse: scan stepped to an index <= the previous index

Behaviour:
- Reset (rst_n low, async): out=0, cur_sel=0, out_valid=0, wrap=0, dwell counter=0, state=S_MAN.
- Single registered stage on every edge: compute sel_nxt; then cur_sel<=sel_nxt and out<=in[sel_nxt*W +: W].
  - out reflects `in` sampled at that edge (latency 1).
- FSM state for the next cycle is chosen by mode and en_mask:
  - S_MAN when mode=0.
  - S_SCAN when mode=1 and en_mask!=0.
  - S_EMPTY when mode=1 and en_mask==0.
- S_MAN:
  - sel_nxt=sel, out_valid<=1, dwell counter held at 0, wrap<=0.
  - If sel>=N_CH: out<=0, out_valid<=0, cur_sel<=sel.
- S_SCAN:
  - Counter cnt runs 0..DWELL-1.
  - Advance when cnt==DWELL-1, or when en_mask[cur_sel]==0 (the current channel is dropped); on advance, cnt<=0.
  - Otherwise sel_nxt=cur_sel and cnt<=cnt+1.
  - Advance target: the first enabled index after cur_sel, searching circularly (cur_sel+1 ... N_CH-1, 0 ... cur_sel).
    - If only cur_sel is enabled, target=cur_sel, the dwell restarts, and wrap pulses.
  - wrap<=1 exactly on advance cycles where target<=cur_sel; otherwise wrap<=0.
  - out_valid<=1.
- Entering S_SCAN from S_MAN or S_EMPTY:
  - cnt<=0.
  - sel_nxt=cur_sel if that index is <N_CH and enabled; otherwise the circular search target from cur_sel (index 0 if cur_sel>=N_CH).
  - No wrap pulse on entry.
- S_EMPTY: cur_sel holds, out<=0, out_valid<=0, wrap<=0, cnt<=0.
- Scan to manual: the next edge follows sel, cnt cleared, wrap<=0.
- en_mask changes mid-dwell: a change to other channels does not affect the current dwell; a change to the current channel takes effect under the drop rule.
- DWELL=1: advance every cycle.
- Reset mid-scan: all outputs and state return to their reset values immediately; scan restarts at channel 0 after release if mode=1.

Decomposition:
- Package mux_scan_pkg: state enum (S_MAN, S_SCAN, S_EMPTY) and a clog2-safe SW helper constant/function.
- Sub-module rr_next_idx: combinational circular "next enabled after index" search.
  - Parameter N_CH.
  - Inputs: mask, cur.
  - Outputs: nxt, wrapped, none.
  - Reused by the future arbiter.

Test Plan:
1. N_CH=8, W=4, mode=0, in=32'h76543210, sel swept 0..7 -> one cycle later out=sel, cur_sel=sel, out_valid=1; reset values all 0 before the first edge.
2. N_CH=8, DWELL=4, mode=1, en_mask=8'hFF -> cur_sel steps 0,1,...,7 every 4 cycles; wrap pulses for exactly 1 cycle when 7->0, every 32 cycles.
3. en_mask=8'b1000_0101, mode=1 -> sequence 0,2,7,0; wrap on 7->0; clearing bit 2 while cur_sel=2 -> next edge cur_sel=7, cnt restarts.
4. en_mask=0 in scan -> out=0, out_valid=0, cur_sel frozen; setting en_mask=8'h10 -> next edge cur_sel=4, out_valid=1, no wrap.
5. N_CH=5 (SW=3), mode=0, sel=6 -> out=0, out_valid=0; switch to mode=1 with en_mask=5'h1F -> cur_sel=0, no wrap.
6. rst_n pulsed low mid-dwell (async, between edges) -> outputs zero immediately; after release with mode=1, scan resumes at cur_sel=0 with a full DWELL.

Source files
------------

// File: rtl/mux_scan_pkg.sv
// Shared types and helpers for the scanning N:1 multiplexer and the
// circular next-index search.
//   state_t    : S_MAN (follow sel), S_SCAN (auto-step), S_EMPTY (scan, no channels)
//   safe_clog2 : $clog2 that never returns 0, so vectors are always at least 1 bit wide
package mux_scan_pkg;

    typedef enum logic [1:0] {
        S_MAN   = 2'd0,
        S_SCAN  = 2'd1,
        S_EMPTY = 2'd2
    } state_t;

    function automatic int safe_clog2(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_next_idx.sv
// Combinational circular search: the first set bit of mask strictly after
// index cur, trying cur+1 .. N_CH-1 and then 0 .. cur. If cur is not a legal
// index (cur >= N_CH), the search starts at 0 instead.
// Ports:
//   mask    : candidate bitmap, bit k stands for index k
//   cur     : starting index, which is excluded until the search wraps back to it
//   nxt     : index that was found (0 when none)
//   wrapped : nxt <= cur, i.e. the search went past the top index
//   none    : mask has no set bit
module rr_next_idx
    import mux_scan_pkg::*;
#(
    parameter  int N_CH = 8,
    localparam int SW   = safe_clog2(N_CH)
) (
    input  logic [N_CH-1:0] mask,
    input  logic [SW-1:0]   cur,
    output logic [SW-1:0]   nxt,
    output logic            wrapped,
    output logic            none
);

    always_comb begin
        int   start;
        int   idx;
        logic found;
        // NOTE: every output gets a default before any conditional assignment,
        // so no path through this block leaves a value unassigned and no latch
        // is inferred.
        nxt     = '0;
        wrapped = 1'b0;
        found   = 1'b0;
        start   = (int'(cur) < N_CH) ? int'(cur) + 1 : 0;
        idx     = 0;
        for (int i = 0; i < N_CH; i++) begin
            idx = start + i;
            if (idx >= N_CH) idx = idx - N_CH;
            if (!found && mask[idx[SW-1:0]]) begin
                found = 1'b1;
                nxt   = idx[SW-1:0];
            end
        end
        none    = !found;
        wrapped = found && (nxt <= cur);
    end

endmodule

// File: rtl/mux_scan_nx1.sv
// Registered N_CH:1 multiplexer of W-bit channels with two modes.
//   manual (mode=0): follows sel. A select beyond the last channel gives out=0
//                    and out_valid=0.
//   scan   (mode=1): holds each enabled channel for DWELL cycles and then steps
//                    to the next enabled one, going round in a circle. wrap
//                    pulses when the step goes down or stays on the same index.
// Ports:
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   in         : packed channels, channel k at in[k*W +: W]
//   sel        : manual-mode channel select
//   mode       : 0 = manual, 1 = scan
//   en_mask    : scan-mode channel enables
//   out        : registered data of channel cur_sel (0 when not valid)
//   cur_sel    : index that drives out
//   out_valid  : out holds a legal channel's data
//   wrap       : one-cycle pulse when scan steps to an index <= the previous one
module mux_scan_nx1
    import mux_scan_pkg::*;
#(
    parameter  int N_CH  = 8,
    parameter  int W     = 1,
    parameter  int DWELL = 4,
    localparam int SW    = safe_clog2(N_CH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_CH*W-1:0] in,
    input  logic [SW-1:0]     sel,
    input  logic              mode,
    input  logic [N_CH-1:0]   en_mask,
    output logic [W-1:0]      out,
    output logic [SW-1:0]     cur_sel,
    output logic              out_valid,
    output logic              wrap
);

    localparam int            CW       = safe_clog2(DWELL);
    localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);

    state_t        state_q, state_nxt;
    logic [CW-1:0] cnt_q, cnt_nxt;
    logic [SW-1:0] sel_nxt;
    logic [W-1:0]  data_nxt;
    logic          valid_nxt, wrap_nxt;
    logic [W-1:0]  ch [N_CH];
    logic [SW-1:0] rr_nxt;
    logic          rr_wrapped, rr_none;
    logic          cur_enabled;

    always_comb begin
        for (int k = 0; k < N_CH; k++) ch[k] = in[k*W +: W];
    end

    // Searches from the index that is currently registered. That covers a
    // normal step, a step after the current channel was dropped, and entry into
    // scan mode (from 0 if a manual select left cur_sel out of range).
    rr_next_idx #(.N_CH(N_CH)) u_rr (
        .mask    (en_mask),
        .cur     (cur_sel),
        .nxt     (rr_nxt),
        .wrapped (rr_wrapped),
        .none    (rr_none)
    );

    // The range test comes first, so an out-of-range manual select never reads
    // past the top of en_mask.
    assign cur_enabled = (int'(cur_sel) < N_CH) && en_mask[cur_sel];

    // rr_none is set exactly when en_mask is all zero.
    always_comb begin
        state_nxt = S_MAN;
        if (mode) state_nxt = rr_none ? S_EMPTY : S_SCAN;
    end

    always_comb begin
        sel_nxt   = cur_sel;
        cnt_nxt   = '0;
        valid_nxt = 1'b0;
        wrap_nxt  = 1'b0;
        unique case (state_nxt)
            S_MAN: begin
                sel_nxt   = sel;
                valid_nxt = (int'(sel) < N_CH);
            end
            S_SCAN: begin
                valid_nxt = 1'b1;
                if (state_q != S_SCAN) begin
                    // Entry: keep the current channel if it may be scanned.
                    // The dwell starts fresh and there is no wrap pulse.
                    sel_nxt = cur_enabled ? cur_sel : rr_nxt;
                end else if (cnt_q == CNT_LAST || !cur_enabled) begin
                    sel_nxt  = rr_nxt;
                    wrap_nxt = rr_wrapped;
                end else begin
                    cnt_nxt = cnt_q + CW'(1);
                end
            end
            default: ; // S_EMPTY: hold cur_sel, output nothing
        endcase
        data_nxt = valid_nxt ? ch[sel_nxt] : '0;
    end

    // NOTE: state is updated only with non-blocking assignments. Every register
    // then samples the values from before the edge, whatever order the
    // statements are written in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_MAN;
            cnt_q     <= '0;
            cur_sel   <= '0;
            out       <= '0;
            out_valid <= 1'b0;
            wrap      <= 1'b0;
        end else begin
            state_q   <= state_nxt;
            cnt_q     <= cnt_nxt;
            cur_sel   <= sel_nxt;
            out       <= data_nxt;
            out_valid <= valid_nxt;
            wrap      <= wrap_nxt;
        end
    end

endmodule

// File: tb/tb_mux_scan_nx1.sv
// Self-checking bench for mux_scan_nx1. Two instances share the clock and
// reset:
//   u_dut8 : N_CH=8, W=4, DWELL=4
//   u_dut5 : N_CH=5, W=4, DWELL=1 (channel count not a power of 2, step every cycle)
// A behavioural model written over plain integers predicts every output after
// every edge. Directed steps cover the listed scenarios, and a randomized
// phase follows them.
`timescale 1ns/1ps
module tb_mux_scan_nx1;

    typedef struct {
        int cur;
        int cnt;
        int st;      // 0 manual, 1 scanning, 2 scan with nothing enabled
        int out;
        bit valid;
        bit wrap;
    } mstate_t;

    localparam int ST_MAN   = 0;
    localparam int ST_SCAN  = 1;
    localparam int ST_EMPTY = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [31:0] in8;   logic [2:0] sel8; logic mode8; logic [7:0] mask8;
    logic [3:0]  out8;  logic [2:0] cur8; logic valid8, wrap8;
    logic [19:0] in5;   logic [2:0] sel5; logic mode5; logic [4:0] mask5;
    logic [3:0]  out5;  logic [2:0] cur5; logic valid5, wrap5;

    mux_scan_nx1 #(.N_CH(8), .W(4), .DWELL(4)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in(in8), .sel(sel8), .mode(mode8),
        .en_mask(mask8), .out(out8), .cur_sel(cur8), .out_valid(valid8), .wrap(wrap8)
    );

    mux_scan_nx1 #(.N_CH(5), .W(4), .DWELL(1)) u_dut5 (
        .clk(clk), .rst_n(rst_n), .in(in5), .sel(sel5), .mode(mode5),
        .en_mask(mask5), .out(out5), .cur_sel(cur5), .out_valid(valid5), .wrap(wrap5)
    );

    int      n_vec    = 0;
    int      n_checks = 0;
    int      n_err    = 0;
    mstate_t m8, m5;

    // ---------------- reference model ----------------
    function automatic mstate_t ref_reset();
        mstate_t r;
        r.cur = 0; r.cnt = 0; r.st = ST_MAN; r.out = 0; r.valid = 1'b0; r.wrap = 1'b0;
        return r;
    endfunction

    function automatic int chan(input logic [63:0] din, input int idx, input int w);
        logic [63:0] v;
        v = din >> (idx * w);
        return int'(v & ((64'd1 << w) - 64'd1));
    endfunction

    // First enabled index after cur, going round in a circle. Starts at 0 if
    // cur is not a legal channel. Returns -1 if nothing is enabled.
    function automatic int next_enabled(input int cur, input int n_ch, input int mask);
        for (int k = 0; k < n_ch; k++) begin
            int idx;
            idx = (cur >= n_ch) ? k : (cur + 1 + k) % n_ch;
            if (((mask >> idx) & 1) != 0) return idx;
        end
        return -1;
    endfunction

    function automatic mstate_t ref_step(input mstate_t s, input int n_ch, input int dwell,
                                         input logic [63:0] din, input int sel,
                                         input bit mode, input int mask);
        mstate_t r;
        int      tgt;
        bit      cur_on;
        r      = s;
        r.wrap = 1'b0;
        tgt    = next_enabled(s.cur, n_ch, mask);
        cur_on = (s.cur < n_ch) && (((mask >> s.cur) & 1) != 0);
        if (!mode) begin
            r.st    = ST_MAN;
            r.cur   = sel;
            r.cnt   = 0;
            r.valid = (sel < n_ch);
            r.out   = r.valid ? chan(din, sel, 4) : 0;
        end else if (mask == 0) begin
            r.st    = ST_EMPTY;
            r.cnt   = 0;
            r.valid = 1'b0;
            r.out   = 0;
        end else begin
            if (s.st != ST_SCAN) begin
                r.cur = cur_on ? s.cur : tgt;
                r.cnt = 0;
            end else if (s.cnt == dwell - 1 || !cur_on) begin
                r.wrap = (tgt <= s.cur);
                r.cur  = tgt;
                r.cnt  = 0;
            end else begin
                r.cnt = s.cnt + 1;
            end
            r.st    = ST_SCAN;
            r.valid = 1'b1;
            r.out   = chan(din, r.cur, 4);
        end
        return r;
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_duts(input string ph);
        check({ph, ":out8"},   32'(out8),   32'(m8.out));
        check({ph, ":cur8"},   32'(cur8),   32'(m8.cur));
        check({ph, ":valid8"}, 32'(valid8), 32'(m8.valid));
        check({ph, ":wrap8"},  32'(wrap8),  32'(m8.wrap));
        check({ph, ":out5"},   32'(out5),   32'(m5.out));
        check({ph, ":cur5"},   32'(cur5),   32'(m5.cur));
        check({ph, ":valid5"}, 32'(valid5), 32'(m5.valid));
        check({ph, ":wrap5"},  32'(wrap5),  32'(m5.wrap));
    endtask

    // One clock edge: advance the models with the inputs seen at that edge,
    // then compare just after it.
    task automatic tick(input string ph);
        @(posedge clk);
        m8 = ref_step(m8, 8, 4, 64'(in8), int'(sel8), mode8, int'(mask8));
        m5 = ref_step(m5, 5, 1, 64'(in5), int'(sel5), mode5, int'(mask5));
        n_vec++;
        #1;
        check_duts(ph);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int wraps;
        bit found;

        rst_n = 1'b1;
        in8 = 32'h7654_3210; sel8 = '0; mode8 = 1'b0; mask8 = '0;
        in5 = 20'h4_3210;    sel5 = '0; mode5 = 1'b0; mask5 = '0;
        m8 = ref_reset();
        m5 = ref_reset();
        #1 rst_n = 1'b0;
        #1 check_duts("reset");
        #2 rst_n = 1'b1;

        // Manual sweep. The 5-channel instance also sees the illegal selects 5..7.
        for (int s = 0; s < 8; s++) begin
            sel8 = 3'(s);
            sel5 = 3'(s);
            tick("man_sweep");
            check("man_out_eq_sel", 32'(out8), 32'(s));
            check("man_cur_eq_sel", 32'(cur8), 32'(s));
            check("man_valid", 32'(valid8), 32'd1);
        end

        // 5-channel instance: out-of-range select, then entry into scan from there.
        sel5 = 3'd6;
        tick("sel_oob");
        check("oob_out", 32'(out5), 32'd0);
        check("oob_valid", 32'(valid5), 32'd0);
        mode5 = 1'b1;
        mask5 = 5'h1F;
        tick("oob_to_scan");
        check("entry_cur0", 32'(cur5), 32'd0);
        check("entry_nowrap", 32'(wrap5), 32'd0);

        // Full scan of 8 channels: one wrap every 32 cycles.
        mode8 = 1'b1;
        mask8 = 8'hFF;
        wraps = 0;
        for (int i = 0; i < 64; i++) begin
            in8 = $urandom;
            in5 = 20'($urandom);
            tick("scan_full");
            if (wrap8) wraps++;
        end
        check("wraps_in_64", 32'(wraps), 32'd2);

        // Sparse mask 0,2,7. Drop channel 2 while it is being held.
        mask8 = 8'b1000_0101;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick("scan_sparse");
            if (cur8 == 3'd2 && m8.cnt == 1) found = 1'b1;
        end
        check("reach_ch2_bound", 32'(found), 32'd1);
        mask8 = 8'b1000_0001;
        tick("drop_cur");
        check("drop_to7", 32'(cur8), 32'd7);
        for (int i = 0; i < 3; i++) begin
            tick("drop_dwell");
            check("drop_hold7", 32'(cur8), 32'd7);
        end
        tick("drop_wrap");
        check("drop_wrap_to0", 32'(cur8), 32'd0);
        check("drop_wrap_pulse", 32'(wrap8), 32'd1);

        // Empty mask in scan mode, then a single channel.
        mask8 = 8'h00;
        for (int i = 0; i < 3; i++) tick("empty");
        check("empty_valid", 32'(valid8), 32'd0);
        check("empty_out", 32'(out8), 32'd0);
        mask8 = 8'h10;
        tick("empty_exit");
        check("exit_cur4", 32'(cur8), 32'd4);
        check("exit_valid", 32'(valid8), 32'd1);
        check("exit_nowrap", 32'(wrap8), 32'd0);

        // Randomized mix of modes, masks, selects and data.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) == 0) mode8 = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 9) == 0) mode5 = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 5) == 0) mask8 = 8'($urandom) & 8'($urandom);
            if ($urandom_range(0, 5) == 0) mask5 = 5'($urandom) & 5'($urandom);
            sel8 = 3'($urandom);
            sel5 = 3'($urandom);
            in8  = $urandom;
            in5  = 20'($urandom);
            tick("random");
        end

        // Asynchronous reset between edges, part-way through a dwell.
        mode8 = 1'b1; mask8 = 8'hFF; mode5 = 1'b1; mask5 = 5'h1F;
        for (int i = 0; i < 6; i++) tick("pre_reset");
        #2 rst_n = 1'b0;
        m8 = ref_reset();
        m5 = ref_reset();
        #1 check_duts("async_reset");
        #3 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick("post_reset");
            check("restart_ch0", 32'(cur8), 32'd0);
        end
        tick("post_reset_step");
        check("restart_step1", 32'(cur8), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
